regblock_x: RTL and testbench
=============================

Name: regblock_x

Overview:
Parametrised successor to the MC6809 register block.
- Keeps the dual read ports and single write port, and adds the optional 6309 registers (W=E:F, V, zero registers), configurable reset vectors and async reset.
- Adds an integrated stack push/pull sequencer that executes PSHS/PSHU/PULS/PULU postbyte masks one byte per memory beat.
- Sits between the microcode sequencer and the bus interface, next to the ALU.

Parameters:
ENABLE_6309, 1, 1 enables W/E/F/V and zero registers; 0 makes those addresses read 16'hBEEF and ignore writes
PC_RESET, 16'hFFFE, PC value after reset
S_RESET, 16'h0F00, S value after reset
U_RESET, 16'h0E00, U value after reset

Ports:
clk_in  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
path_left_addr  in  4  left read port register number
path_right_addr  in  4  right read port register number
path_left_data  out  16  left read data, combinational
path_right_data  out  16  right read data, combinational
write_reg  in  1  write data_w to write_reg_addr
write_reg_addr  in  4  write register number
data_w  in  16  write data; 8-bit registers take [7:0]
write_flags  in  1  load CC from CCR_in
CCR_in  in  8  new CC
write_pc  in  1  load PC from new_pc
new_pc  in  16  PC load value
inc_pc  in  1  PC <= PC+1
CCR_o  out  8  current CC
reg_pc  out  16  current PC
reg_dp  out  8  current DP
reg_s  out  16  current S
reg_u  out  16  current U
stk_start  in  1  start stack operation (sampled only when idle)
stk_pull  in  1  1=pull, 0=push; sampled with stk_start
stk_use_s  in  1  1=S stack (other stack is U), 0=U stack (other is S); sampled with stk_start
stk_mask  in  8  postbyte: b7 PC, b6 other stack ptr, b5 Y, b4 X, b3 DP, b2 B, b1 A, b0 CC
stk_busy  out  1  sequencer active
stk_done  out  1  one-cycle completion pulse
mem_addr  out  16  beat address
mem_wdata  out  8  push byte
mem_we  out  1  push beat request
mem_re  out  1  pull beat request
mem_rdata  in  8  pull byte, valid with mem_ready
mem_ready  in  1  beat completes in this cycle

Behaviour:
- Register numbers: 0 D, 1 X, 2 Y, 3 U, 4 S, 5 PC, 6 W, 7 V, 8 A, 9 B, 10 CC, 11 DP, 12 zero, 13 zero, 14 E, 15 F.
- 8-bit registers read zero-extended. Zero registers read 0 and ignore writes. Numbers 6, 7, 12-15 read 16'hBEEF when ENABLE_6309=0.
- Both read ports decode identically; the right port can read PC.
- Reset (async, reset_n low): PC=PC_RESET, S=S_RESET, U=U_RESET, CC=8'h50; D, X, Y, DP, W, V = 0. Sequencer goes to IDLE; stk_busy, stk_done, mem_we, mem_re = 0; mem_addr = 0. Reset aborts any in-flight operation.
- Same-cycle write priority, lowest to highest: write_reg, write_flags, write_pc, inc_pc.
- While stk_busy=1, write_reg, write_flags, write_pc and inc_pc are ignored; the sequencer has sole write access.
- States: IDLE, PUSH, PULL, DONE.
- IDLE to PUSH/PULL: on stk_start with mask≠0. The mask, direction and stack select are latched, and stk_busy=1 from the next cycle.
- IDLE to DONE: on stk_start with mask=0; no memory beats occur.
- Push byte order (descending addresses): PC lo, PC hi, other-SP lo, other-SP hi, Y lo, Y hi, X lo, X hi, DP, B, A, CC. Bytes for clear mask bits are skipped.
- Push beat: mem_we=1, mem_addr=SP-1, mem_wdata=byte. When mem_ready=1 that cycle: SP <= SP-1, advance to the next byte.
- Pull byte order: exact reverse of push (CC first, PC lo last).
- Pull beat: mem_re=1, mem_addr=SP. When mem_ready=1: the byte is written into its register half, SP <= SP+1, advance.
- With mem_ready=0, the beat request holds with stable address and data.
- After the last beat completes: DONE for one cycle (stk_done=1, stk_busy=0, no mem request), then IDLE.
- SP arithmetic wraps modulo 2^16.
- A new stk_start is accepted only in IDLE, so the earliest is the cycle after stk_done.

Test Plan:
- Reset: assert reset_n=0 mid-push -> reg_pc=FFFE, reg_s=0F00, reg_u=0E00, CCR_o=50, stk_busy=0 immediately, without waiting for a clock edge.
- Writes/reads: write X=1234, then A=AB, B=CD -> left reads 1234 on addr 1; right reads ABCD on addr 0. With ENABLE_6309=0, addr 6 reads BEEF.
- PSHS mask FF, S=0F00, mem_ready=1 every cycle -> 12 beats at 0EFF..0EF4, bytes in push order. Then S=0EF4, stk_done high for one cycle.
- PULU mask 81 on that memory image -> CC then PC hi/lo loaded, U advanced by 3, stk_done pulse.
- Push with mem_ready low for 3 cycles per beat -> mem_addr/mem_wdata held stable; final result identical to zero-wait run.
- mask=00 -> stk_done the cycle after stk_start, no mem_we/mem_re. S=0000 with a push of CC -> write at FFFF, S=FFFF.

Source files
------------

// File: rtl/regblock_x.sv
// regblock_x: 6809/6309 register file with two read ports and one write port,
// plus a PSHS/PSHU/PULS/PULU sequencer that moves one byte per memory beat.
module regblock_x #(
    parameter bit          ENABLE_6309 = 1'b1,
    parameter logic [15:0] PC_RESET    = 16'hFFFE,
    parameter logic [15:0] S_RESET     = 16'h0F00,
    parameter logic [15:0] U_RESET     = 16'h0E00
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic [3:0]  path_left_addr,
    input  logic [3:0]  path_right_addr,
    output logic [15:0] path_left_data,
    output logic [15:0] path_right_data,
    input  logic        write_reg,
    input  logic [3:0]  write_reg_addr,
    input  logic [15:0] data_w,
    input  logic        write_flags,
    input  logic [7:0]  CCR_in,
    input  logic        write_pc,
    input  logic [15:0] new_pc,
    input  logic        inc_pc,
    output logic [7:0]  CCR_o,
    output logic [15:0] reg_pc,
    output logic [7:0]  reg_dp,
    output logic [15:0] reg_s,
    output logic [15:0] reg_u,
    input  logic        stk_start,
    input  logic        stk_pull,
    input  logic        stk_use_s,
    input  logic [7:0]  stk_mask,
    output logic        stk_busy,
    output logic        stk_done,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PUSH = 2'd1;
    localparam logic [1:0] ST_PULL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [7:0]  a_q, a_d, b_q, b_d, e_q, e_d, f_q, f_d, cc_q, cc_d, dp_q, dp_d;
    logic [15:0] x_q, x_d, y_q, y_d, u_q, u_d, s_q, s_d, pc_q, pc_d, v_q, v_d;
    logic [1:0]  state_q, state_d;
    // One pending bit per stacked byte, bit 0 = PC lo ... bit 11 = CC (push order)
    logic [11:0] pend_q, pend_d;
    logic        use_s_q, use_s_d;
    logic [15:0] sp, osp;
    logic [3:0]  idx;
    logic [7:0]  beat_byte;
    logic        busy;

    function automatic logic [15:0] read_reg(
        input logic [3:0]  n,
        input logic [7:0]  a, b, e, f, cc, dp,
        input logic [15:0] x, y, u, s, pc, v
    );
        logic [15:0] r;
        case (n)
            4'd0:    r = {a, b};
            4'd1:    r = x;
            4'd2:    r = y;
            4'd3:    r = u;
            4'd4:    r = s;
            4'd5:    r = pc;
            4'd6:    r = ENABLE_6309 ? {e, f} : 16'hBEEF;
            4'd7:    r = ENABLE_6309 ? v : 16'hBEEF;
            4'd8:    r = {8'h00, a};
            4'd9:    r = {8'h00, b};
            4'd10:   r = {8'h00, cc};
            4'd11:   r = {8'h00, dp};
            4'd14:   r = ENABLE_6309 ? {8'h00, e} : 16'hBEEF;
            4'd15:   r = ENABLE_6309 ? {8'h00, f} : 16'hBEEF;
            default: r = ENABLE_6309 ? 16'h0000 : 16'hBEEF;
        endcase
        return r;
    endfunction

    // Combinational read ports
    always_comb begin
        path_left_data  = read_reg(path_left_addr, a_q, b_q, e_q, f_q, cc_q, dp_q,
                                   x_q, y_q, u_q, s_q, pc_q, v_q);
        path_right_data = read_reg(path_right_addr, a_q, b_q, e_q, f_q, cc_q, dp_q,
                                   x_q, y_q, u_q, s_q, pc_q, v_q);
    end

    // Pick the current beat: lowest pending byte when pushing, highest when pulling
    always_comb begin
        sp  = use_s_q ? s_q : u_q;
        osp = use_s_q ? u_q : s_q;
        idx = '0;
        if (state_q == ST_PULL) begin
            for (int unsigned i = 0; i < 12; i++)
                if (pend_q[i]) idx = 4'(i);
        end else begin
            for (int unsigned i = 12; i > 0; i--)
                if (pend_q[i-1]) idx = 4'(i - 1);
        end
        case (idx)
            4'd0:    beat_byte = pc_q[7:0];
            4'd1:    beat_byte = pc_q[15:8];
            4'd2:    beat_byte = osp[7:0];
            4'd3:    beat_byte = osp[15:8];
            4'd4:    beat_byte = y_q[7:0];
            4'd5:    beat_byte = y_q[15:8];
            4'd6:    beat_byte = x_q[7:0];
            4'd7:    beat_byte = x_q[15:8];
            4'd8:    beat_byte = dp_q;
            4'd9:    beat_byte = b_q;
            4'd10:   beat_byte = a_q;
            default: beat_byte = cc_q;
        endcase
    end

    // Next-state: external writes when idle, sequencer owns the registers when busy
    always_comb begin
        a_d = a_q;   b_d = b_q;   e_d = e_q;   f_d = f_q;   cc_d = cc_q; dp_d = dp_q;
        x_d = x_q;   y_d = y_q;   u_d = u_q;   s_d = s_q;   pc_d = pc_q; v_d = v_q;
        state_d = state_q;
        pend_d  = pend_q;
        use_s_d = use_s_q;
        busy    = (state_q == ST_PUSH) || (state_q == ST_PULL);

        if (!busy) begin
            if (write_reg) begin
                case (write_reg_addr)
                    4'd0:  begin a_d = data_w[15:8]; b_d = data_w[7:0]; end
                    4'd1:  x_d = data_w;
                    4'd2:  y_d = data_w;
                    4'd3:  u_d = data_w;
                    4'd4:  s_d = data_w;
                    4'd5:  pc_d = data_w;
                    4'd6:  if (ENABLE_6309) begin e_d = data_w[15:8]; f_d = data_w[7:0]; end
                    4'd7:  if (ENABLE_6309) v_d = data_w;
                    4'd8:  a_d = data_w[7:0];
                    4'd9:  b_d = data_w[7:0];
                    4'd10: cc_d = data_w[7:0];
                    4'd11: dp_d = data_w[7:0];
                    4'd14: if (ENABLE_6309) e_d = data_w[7:0];
                    4'd15: if (ENABLE_6309) f_d = data_w[7:0];
                    default: ;
                endcase
            end
            if (write_flags) cc_d = CCR_in;
            if (write_pc)    pc_d = new_pc;
            if (inc_pc)      pc_d = pc_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (stk_start) begin
                    use_s_d = stk_use_s;
                    pend_d  = {stk_mask[0], stk_mask[1], stk_mask[2], stk_mask[3],
                               {2{stk_mask[4]}}, {2{stk_mask[5]}},
                               {2{stk_mask[6]}}, {2{stk_mask[7]}}};
                    if (stk_mask == 8'h00) state_d = ST_DONE;
                    else                   state_d = stk_pull ? ST_PULL : ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (mem_ready) begin
                    if (use_s_q) s_d = s_q - 16'd1;
                    else         u_d = u_q - 16'd1;
                    pend_d[idx] = 1'b0;
                    if (pend_d == '0) state_d = ST_DONE;
                end
            end
            ST_PULL: begin
                if (mem_ready) begin
                    if (use_s_q) s_d = s_q + 16'd1;
                    else         u_d = u_q + 16'd1;
                    case (idx)
                        4'd0:  pc_d[7:0]  = mem_rdata;
                        4'd1:  pc_d[15:8] = mem_rdata;
                        4'd2:  if (use_s_q) u_d[7:0]  = mem_rdata; else s_d[7:0]  = mem_rdata;
                        4'd3:  if (use_s_q) u_d[15:8] = mem_rdata; else s_d[15:8] = mem_rdata;
                        4'd4:  y_d[7:0]  = mem_rdata;
                        4'd5:  y_d[15:8] = mem_rdata;
                        4'd6:  x_d[7:0]  = mem_rdata;
                        4'd7:  x_d[15:8] = mem_rdata;
                        4'd8:  dp_d = mem_rdata;
                        4'd9:  b_d  = mem_rdata;
                        4'd10: a_d  = mem_rdata;
                        default: cc_d = mem_rdata;
                    endcase
                    pend_d[idx] = 1'b0;
                    if (pend_d == '0) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0; b_q <= '0; e_q <= '0; f_q <= '0; cc_q <= 8'h50; dp_q <= '0;
            x_q <= '0; y_q <= '0; u_q <= U_RESET; s_q <= S_RESET; pc_q <= PC_RESET; v_q <= '0;
            state_q <= ST_IDLE;
            pend_q  <= '0;
            use_s_q <= 1'b0;
        end else begin
            a_q <= a_d; b_q <= b_d; e_q <= e_d; f_q <= f_d; cc_q <= cc_d; dp_q <= dp_d;
            x_q <= x_d; y_q <= y_d; u_q <= u_d; s_q <= s_d; pc_q <= pc_d; v_q <= v_d;
            state_q <= state_d;
            pend_q  <= pend_d;
            use_s_q <= use_s_d;
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        CCR_o     = cc_q;
        reg_pc    = pc_q;
        reg_dp    = dp_q;
        reg_s     = s_q;
        reg_u     = u_q;
        stk_busy  = busy;
        stk_done  = (state_q == ST_DONE);
        mem_we    = (state_q == ST_PUSH);
        mem_re    = (state_q == ST_PULL);
        mem_addr  = (state_q == ST_PUSH) ? sp - 16'd1 :
                    (state_q == ST_PULL) ? sp : '0;
        mem_wdata = (state_q == ST_PUSH) ? beat_byte : '0;
    end
endmodule

// File: tb/tb_regblock_x.sv
// Directed bench for regblock_x with a memory-beat scoreboard.
module tb_regblock_x;
    logic        clk_in = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  path_left_addr = '0, path_right_addr = '0;
    logic [15:0] path_left_data, path_right_data;
    logic        write_reg = 0, write_flags = 0, write_pc = 0, inc_pc = 0;
    logic [3:0]  write_reg_addr = '0;
    logic [15:0] data_w = '0, new_pc = '0;
    logic [7:0]  CCR_in = '0;
    logic [7:0]  CCR_o, reg_dp;
    logic [15:0] reg_pc, reg_s, reg_u;
    logic        stk_start = 0, stk_pull = 0, stk_use_s = 0;
    logic [7:0]  stk_mask = '0;
    logic        stk_busy, stk_done, mem_we, mem_re;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ready = 0;

    logic [15:0] d2_l, d2_r, d2_pc, d2_s, d2_u, d2_addr;
    logic [7:0]  d2_cc, d2_dp, d2_wdata;
    logic        d2_busy, d2_done, d2_we, d2_re;

    typedef struct packed { logic we; logic [15:0] addr; logic [7:0] data; } beat_t;
    beat_t       exp_q[$];
    logic [7:0]  mem [0:65535];
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc;

    always #5 clk_in = ~clk_in;

    regblock_x dut (
        .clk_in(clk_in), .reset_n(reset_n),
        .path_left_addr(path_left_addr), .path_right_addr(path_right_addr),
        .path_left_data(path_left_data), .path_right_data(path_right_data),
        .write_reg(write_reg), .write_reg_addr(write_reg_addr), .data_w(data_w),
        .write_flags(write_flags), .CCR_in(CCR_in), .write_pc(write_pc), .new_pc(new_pc),
        .inc_pc(inc_pc), .CCR_o(CCR_o), .reg_pc(reg_pc), .reg_dp(reg_dp), .reg_s(reg_s),
        .reg_u(reg_u), .stk_start(stk_start), .stk_pull(stk_pull), .stk_use_s(stk_use_s),
        .stk_mask(stk_mask), .stk_busy(stk_busy), .stk_done(stk_done), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    regblock_x #(.ENABLE_6309(1'b0)) dut_6809 (
        .clk_in(clk_in), .reset_n(reset_n),
        .path_left_addr(path_left_addr), .path_right_addr(path_right_addr),
        .path_left_data(d2_l), .path_right_data(d2_r),
        .write_reg(write_reg), .write_reg_addr(write_reg_addr), .data_w(data_w),
        .write_flags(write_flags), .CCR_in(CCR_in), .write_pc(write_pc), .new_pc(new_pc),
        .inc_pc(inc_pc), .CCR_o(d2_cc), .reg_pc(d2_pc), .reg_dp(d2_dp), .reg_s(d2_s),
        .reg_u(d2_u), .stk_start(1'b0), .stk_pull(1'b0), .stk_use_s(1'b0),
        .stk_mask(8'h00), .stk_busy(d2_busy), .stk_done(d2_done), .mem_addr(d2_addr),
        .mem_wdata(d2_wdata), .mem_we(d2_we), .mem_re(d2_re), .mem_rdata(8'h00),
        .mem_ready(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        write_reg = 1; write_reg_addr = a; data_w = d;
        @(negedge clk_in);
        write_reg = 0;
    endtask

    // Build the expected beat list for a stack op from the architectural rules
    task automatic plan(input bit pull, input logic [15:0] sp0, input logic [7:0] m,
                        input logic [15:0] pc, input logic [15:0] osp, input logic [15:0] y,
                        input logic [15:0] x, input logic [7:0] dp, input logic [7:0] b,
                        input logic [7:0] a, input logic [7:0] cc);
        logic [7:0]  by [12];
        int          grp [12];
        logic [15:0] sp;
        by  = '{pc[7:0], pc[15:8], osp[7:0], osp[15:8], y[7:0], y[15:8],
                x[7:0], x[15:8], dp, b, a, cc};
        grp = '{7, 7, 6, 6, 5, 5, 4, 4, 3, 2, 1, 0};
        sp  = sp0;
        if (!pull) begin
            for (int i = 0; i < 12; i++)
                if (m[grp[i]]) begin sp = sp - 16'd1; exp_q.push_back('{1'b1, sp, by[i]}); end
        end else begin
            for (int i = 11; i >= 0; i--)
                if (m[grp[i]]) begin exp_q.push_back('{1'b0, sp, 8'h00}); sp = sp + 16'd1; end
        end
    endtask

    task automatic start(input bit pull, input bit use_s, input logic [7:0] m);
        stk_start = 1; stk_pull = pull; stk_use_s = use_s; stk_mask = m;
    endtask

    // Memory responder: serves beats after ws wait cycles, pops and checks the scoreboard
    task automatic run_op(input int ws, input int budget, output int cycles);
        int          waits;
        bit          done_seen;
        logic [15:0] hold_a;
        logic [7:0]  hold_d;
        beat_t       e;
        waits = 0; done_seen = 0; cycles = -1; hold_a = '0; hold_d = '0;
        for (int c = 0; c < budget && !done_seen; c++) begin
            @(negedge clk_in);
            stk_start = 0;
            if (stk_done) begin
                done_seen = 1; cycles = c; mem_ready = 0;
            end else if (mem_we || mem_re) begin
                if (waits < ws) begin
                    if (waits == 0) begin hold_a = mem_addr; hold_d = mem_wdata; end
                    else begin
                        check("hold_addr", mem_addr, hold_a);
                        check("hold_wdata", mem_wdata, hold_d);
                    end
                    waits++; mem_ready = 0;
                end else begin
                    check("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat_dir_we", mem_we, e.we);
                        check("beat_addr", mem_addr, e.addr);
                        if (mem_we) begin
                            check("beat_wdata", mem_wdata, e.data);
                            mem[mem_addr] = mem_wdata;
                        end else begin
                            mem_rdata = mem[mem_addr];
                        end
                    end
                    waits = 0; mem_ready = 1;
                end
            end else begin
                mem_ready = 0;
            end
        end
        check("done_within_budget", done_seen, 1);
        check("done_busy_low", stk_busy, 0);
        check("done_no_mem_req", {mem_we, mem_re}, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        @(negedge clk_in);
        check("done_one_cycle", stk_done, 0);
    endtask

    initial begin
        #1 reset_n = 0;
        #1;
        check("rst_pc", reg_pc, 16'hFFFE);
        check("rst_s", reg_s, 16'h0F00);
        check("rst_u", reg_u, 16'h0E00);
        check("rst_cc", CCR_o, 8'h50);
        check("rst_busy_done", {stk_busy, stk_done, mem_we, mem_re}, 0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        @(negedge clk_in);
        @(negedge clk_in);
        reset_n = 1;
        @(negedge clk_in);

        // Register writes and both read ports
        wr(4'd1, 16'h1234); wr(4'd8, 16'h00AB); wr(4'd9, 16'h00CD);
        wr(4'd2, 16'h5678); wr(4'd11, 16'h0012); wr(4'd6, 16'h1122); wr(4'd12, 16'hFFFF);
        path_left_addr = 4'd1; path_right_addr = 4'd0; #1;
        check("read_x", path_left_data, 16'h1234);
        check("read_d", path_right_data, 16'hABCD);
        path_left_addr = 4'd14; path_right_addr = 4'd15; #1;
        check("read_e", path_left_data, 16'h0011);
        check("read_f", path_right_data, 16'h0022);
        path_left_addr = 4'd6; path_right_addr = 4'd5; #1;
        check("read_w", path_left_data, 16'h1122);
        check("read_pc_right", path_right_data, 16'hFFFE);
        check("read_w_6809", d2_l, 16'hBEEF);
        path_left_addr = 4'd12; path_right_addr = 4'd8; #1;
        check("read_zero", path_left_data, 16'h0000);
        check("read_a_zext", path_right_data, 16'h00AB);
        check("read_zero_6809", d2_l, 16'hBEEF);

        // Same-cycle write priority
        write_reg = 1; write_reg_addr = 4'd10; data_w = 16'h0055;
        write_flags = 1; CCR_in = 8'hAA; write_pc = 1; new_pc = 16'h2222;
        @(negedge clk_in);
        check("prio_flags_over_reg", CCR_o, 8'hAA);
        check("prio_pc_load", reg_pc, 16'h2222);
        write_flags = 0; write_reg_addr = 4'd5; data_w = 16'h1111; new_pc = 16'h3333; inc_pc = 1;
        @(negedge clk_in);
        check("prio_inc_wins", reg_pc, 16'h2223);
        write_reg = 0; write_pc = 0; inc_pc = 0;
        wr(4'd3, 16'h3000);

        // PSHS #$FF, zero wait states
        plan(0, 16'h0F00, 8'hFF, 16'h2223, 16'h3000, 16'h5678, 16'h1234, 8'h12, 8'hCD, 8'hAB, 8'hAA);
        start(0, 1, 8'hFF);
        run_op(0, 40, cyc);
        check("pshs_cycles", cyc, 12);
        check("pshs_s", reg_s, 16'h0EF4);
        check("pshs_u_kept", reg_u, 16'h3000);

        // PULU #$81 from the pushed image: CC, PC hi, PC lo
        wr(4'd3, 16'h0EF4);
        plan(1, 16'h0EF4, 8'h81, '0, '0, '0, '0, '0, '0, '0, '0);
        start(1, 0, 8'h81);
        run_op(0, 20, cyc);
        check("pulu_cc", CCR_o, 8'hAA);
        check("pulu_pc", reg_pc, 16'hABCD);
        check("pulu_u", reg_u, 16'h0EF7);
        check("pulu_s_kept", reg_s, 16'h0EF4);

        // PSHU #$FF with three wait cycles per beat
        plan(0, 16'h0EF7, 8'hFF, 16'hABCD, 16'h0EF4, 16'h5678, 16'h1234, 8'h12, 8'hCD, 8'hAB, 8'hAA);
        start(0, 0, 8'hFF);
        run_op(3, 100, cyc);
        check("pshu_ws_cycles", cyc, 48);
        check("pshu_ws_u", reg_u, 16'h0EEB);
        check("pshu_ws_s_kept", reg_s, 16'h0EF4);

        // Empty mask: straight to DONE
        start(0, 1, 8'h00);
        run_op(0, 5, cyc);
        check("mask0_latency", cyc, 0);
        check("mask0_s", reg_s, 16'h0EF4);

        // Stack pointer wraps below zero
        wr(4'd4, 16'h0000);
        plan(0, 16'h0000, 8'h01, '0, '0, '0, '0, '0, '0, '0, 8'hAA);
        start(0, 1, 8'h01);
        run_op(0, 10, cyc);
        check("wrap_s", reg_s, 16'hFFFF);

        // Writes ignored while busy, then async reset mid-push
        start(0, 1, 8'hFF);
        @(negedge clk_in);
        stk_start = 0; mem_ready = 0; write_pc = 1; new_pc = 16'h0000;
        @(negedge clk_in);
        check("busy_mid_push", {stk_busy, mem_we}, 2'b11);
        check("busy_blocks_pc_write", reg_pc, 16'hABCD);
        #1 reset_n = 0;
        #1;
        check("abort_pc", reg_pc, 16'hFFFE);
        check("abort_s", reg_s, 16'h0F00);
        check("abort_u", reg_u, 16'h0E00);
        check("abort_cc", CCR_o, 8'h50);
        check("abort_busy", {stk_busy, mem_we, mem_re, stk_done}, 0);
        write_pc = 0;
        @(negedge clk_in);
        reset_n = 1;
        @(negedge clk_in);
        check("post_reset_idle", stk_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
